// File: rtl/rv32_types.sv
// Shared types for the rv32 decode hazard unit: register ids, in-flight entries
// and the bypass select encoding (0 = register file, k+1 = stage k, DEPTH+1 = completion bus).
package rv32_types;

  localparam int REG_ID_W = 5;
  localparam int STAGE_W  = 4;

  typedef logic [REG_ID_W-1:0] rv_reg_id_t;
  typedef logic [STAGE_W-1:0]  rv_stage_t;

  typedef struct packed {
    logic       valid;
    rv_reg_id_t rd;
    rv_stage_t  ready_stage;
  } inflight_entry_t;

  localparam int NO_BYPASS = 0;

  // Select width depends on the bypass depth, so the "type" is a width function.
  function automatic int bypass_width(input int depth);
    return $clog2(depth + 2);
  endfunction

  function automatic int stage_sel(input int k);
    return k + 1;
  endfunction

  function automatic int complete_sel(input int depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/rv32_hdu_inflight_shift.sv
// Post-decode in-flight writer tracking: a shift register of BYPASS_DEPTH entries
// plus a per-source youngest-match search returning {hit, k, ready}.
module rv32_hdu_inflight_shift
  import rv32_types::*;
#(
  parameter int NUM_RS       = 2,
  parameter int BYPASS_DEPTH = 2,
  parameter int KW           = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       advance,
  input  inflight_entry_t            stage0_entry,
  input  logic [NUM_RS*REG_ID_W-1:0] rs,
  output logic [NUM_RS-1:0]          hit,
  output logic [NUM_RS*KW-1:0]       k,
  output logic [NUM_RS-1:0]          ready
);

  inflight_entry_t entries [BYPASS_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < BYPASS_DEPTH; s++) entries[s] <= '0;
    end else if (advance) begin
      entries[0] <= stage0_entry;
      for (int s = 1; s < BYPASS_DEPTH; s++) entries[s] <= entries[s-1];
    end
  end

  // Scan oldest to youngest so the lowest matching stage is the one left standing.
  always_comb begin
    hit   = '0;
    k     = '0;
    ready = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      for (int s = BYPASS_DEPTH - 1; s >= 0; s--) begin
        if (entries[s].valid && entries[s].rd == rs[i*REG_ID_W +: REG_ID_W]) begin
          hit[i]          = 1'b1;
          k[i*KW +: KW]   = KW'(s);
          ready[i]        = (s >= int'(entries[s].ready_stage));
        end
      end
    end
  end

endmodule

// File: rtl/rv32_scoreboard_hazard_unit.sv
// Decode-stage hazard unit: in-flight bypass selection, long-op busy scoreboard and stall.
// Optional RV32_HDU_COMPLETE_BYPASS_EN forwards the long-unit completion bus to waiting sources.
module rv32_scoreboard_hazard_unit
  import rv32_types::*;
#(
  parameter int NUM_RS           = 2,
  parameter int BYPASS_DEPTH     = 2,
  parameter int LOAD_READY_STAGE = 1,
  parameter int LONG_MAX         = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       advance,
  input  logic                                       flush,
  input  logic                                       issue_valid,
  input  logic [NUM_RS-1:0]                          issue_use_rs,
  input  logic [NUM_RS*5-1:0]                        issue_rs,
  input  logic [4:0]                                 issue_rd,
  input  logic                                       issue_wb,
  input  logic                                       issue_is_load,
  input  logic                                       issue_is_long,
  input  logic                                       complete_valid,
  input  logic [4:0]                                 complete_rd,
  output logic                                       stall,
  output logic [NUM_RS*$clog2(BYPASS_DEPTH+2)-1:0]   bypass_rs,
  output logic [$clog2(LONG_MAX+1)-1:0]              long_pending
);

  localparam int BW = bypass_width(BYPASS_DEPTH);
  localparam int PW = $clog2(LONG_MAX + 1);
  localparam int KW = (BYPASS_DEPTH > 1) ? $clog2(BYPASS_DEPTH) : 1;
  localparam logic [BW-1:0] SEL_COMPLETE = BW'(complete_sel(BYPASS_DEPTH));

  logic [31:0]          long_busy;
  logic [31:0]          busy_next;
  logic [NUM_RS-1:0]    src_hit;
  logic [NUM_RS-1:0]    src_ready;
  logic [NUM_RS-1:0]    src_stall;
  logic [NUM_RS*KW-1:0] src_k;
  logic                 accepted;
  logic                 waw;
  logic                 long_full;
  logic                 long_inc;
  logic                 long_dec;
  logic                 cpl_match;
  rv_reg_id_t           rs_cur;
  inflight_entry_t      stage0_entry;

  rv32_hdu_inflight_shift #(
    .NUM_RS       (NUM_RS),
    .BYPASS_DEPTH (BYPASS_DEPTH),
    .KW           (KW)
  ) u_inflight (
    .clk          (clk),
    .rst          (rst),
    .advance      (advance),
    .stage0_entry (stage0_entry),
    .rs           (issue_rs),
    .hit          (src_hit),
    .k            (src_k),
    .ready        (src_ready)
  );

  // Long ops never enter the shift register; their result arrives via the completion port.
  always_comb begin
    stage0_entry.valid       = accepted & issue_wb & (issue_rd != '0) & ~issue_is_long;
    stage0_entry.rd          = issue_rd;
    stage0_entry.ready_stage = issue_is_load ? rv_stage_t'(LOAD_READY_STAGE) : '0;
  end

  // The scoreboard takes precedence over any in-flight match for the same register.
  always_comb begin
    src_stall = '0;
    bypass_rs = '0;
    rs_cur    = '0;
    cpl_match = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NUM_RS; i++) begin
        rs_cur = issue_rs[i*5 +: 5];
`ifdef RV32_HDU_COMPLETE_BYPASS_EN
        cpl_match = complete_valid && (complete_rd == rs_cur);
`else
        cpl_match = 1'b0;
`endif
        if (issue_use_rs[i] && rs_cur != '0) begin
          if (long_busy[rs_cur]) begin
            if (cpl_match) bypass_rs[i*BW +: BW] = SEL_COMPLETE;
            else           src_stall[i] = 1'b1;
          end else if (src_hit[i]) begin
            if (src_ready[i]) bypass_rs[i*BW +: BW] = BW'(stage_sel(int'(src_k[i*KW +: KW])));
            else              src_stall[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    waw       = issue_wb & (issue_rd != '0) & long_busy[issue_rd];
    long_full = issue_is_long & (long_pending == PW'(LONG_MAX));
    stall     = issue_valid & ~rst & ((|src_stall) | waw | long_full);
    accepted  = issue_valid & ~stall & ~flush & advance;
    long_inc  = accepted & issue_is_long;
    long_dec  = complete_valid & (long_pending != '0);
  end

  // Clear first, then set, so a same-cycle issue to the completing register stays busy.
  always_comb begin
    busy_next = long_busy;
    if (complete_valid) busy_next[complete_rd] = 1'b0;
    if (accepted && issue_is_long && issue_wb && issue_rd != '0) busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_busy    <= '0;
      long_pending <= '0;
    end else begin
      long_busy <= busy_next;
      if (long_inc && !long_dec)      long_pending <= long_pending + PW'(1);
      else if (!long_inc && long_dec) long_pending <= long_pending - PW'(1);
    end
  end

endmodule

// File: tb/tb_rv32_scoreboard_hazard_unit.sv
// Self-checking bench for rv32_scoreboard_hazard_unit: directed scenarios plus
// randomized traffic compared against a queue-of-writers reference model.
module tb_rv32_scoreboard_hazard_unit;

  localparam int NUM_RS   = 2;
  localparam int DEPTH    = 2;
  localparam int LRS      = 1;
  localparam int LONG_MAX = 4;

`ifdef RV32_HDU_COMPLETE_BYPASS_EN
  localparam bit CPL_FWD = 1'b1;
`else
  localparam bit CPL_FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       advance;
  logic       flush;
  logic       issue_valid;
  logic [1:0] issue_use_rs;
  logic [9:0] issue_rs;
  logic [4:0] issue_rd;
  logic       issue_wb;
  logic       issue_is_load;
  logic       issue_is_long;
  logic       complete_valid;
  logic [4:0] complete_rd;
  logic       stall;
  logic [3:0] bypass_rs;
  logic [2:0] long_pending;

  int checks = 0;
  int fails  = 0;

  rv32_scoreboard_hazard_unit #(
    .NUM_RS           (NUM_RS),
    .BYPASS_DEPTH     (DEPTH),
    .LOAD_READY_STAGE (LRS),
    .LONG_MAX         (LONG_MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .advance        (advance),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_use_rs   (issue_use_rs),
    .issue_rs       (issue_rs),
    .issue_rd       (issue_rd),
    .issue_wb       (issue_wb),
    .issue_is_load  (issue_is_load),
    .issue_is_long  (issue_is_long),
    .complete_valid (complete_valid),
    .complete_rd    (complete_rd),
    .stall          (stall),
    .bypass_rs      (bypass_rs),
    .long_pending   (long_pending)
  );

  always #5 clk = ~clk;

  // Reference model: the register written by the instruction k advances ago (0 = none),
  // whether it was a load, the set of registers owed by the long unit and its count.
  int       m_pipe_rd [DEPTH];
  bit       m_pipe_ld [DEPTH];
  bit [31:0] m_busy;
  int       m_pending;

  function automatic void model_eval(output logic st, output logic [3:0] byp);
    bit any;
    bit found;
    int r;
    any = 1'b0;
    byp = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      r = int'(issue_rs[i*5 +: 5]);
      if (issue_use_rs[i] && r != 0) begin
        if (m_busy[r]) begin
          if (CPL_FWD && complete_valid && int'(complete_rd) == r) byp[i*2 +: 2] = 2'(DEPTH + 1);
          else any = 1'b1;
        end else begin
          found = 1'b0;
          for (int s = 0; s < DEPTH; s++) begin
            if (!found && m_pipe_rd[s] == r) begin
              found = 1'b1;
              if (!m_pipe_ld[s] || s >= LRS) byp[i*2 +: 2] = 2'(s + 1);
              else any = 1'b1;
            end
          end
        end
      end
    end
    if (issue_wb && issue_rd != 0 && m_busy[issue_rd]) any = 1'b1;
    if (issue_is_long && m_pending == LONG_MAX) any = 1'b1;
    st = issue_valid && any;
    if (rst) begin
      st  = 1'b0;
      byp = '0;
    end
  endfunction

  always @(posedge clk) begin
    logic st;
    logic [3:0] byp;
    bit acc;
    model_eval(st, byp);
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        m_pipe_rd[s] = 0;
        m_pipe_ld[s] = 1'b0;
      end
      m_busy    = '0;
      m_pending = 0;
    end else begin
      acc = issue_valid && !st && !flush && advance;
      if (advance) begin
        for (int s = DEPTH - 1; s > 0; s--) begin
          m_pipe_rd[s] = m_pipe_rd[s-1];
          m_pipe_ld[s] = m_pipe_ld[s-1];
        end
        m_pipe_rd[0] = (acc && issue_wb && !issue_is_long) ? int'(issue_rd) : 0;
        m_pipe_ld[0] = issue_is_load;
      end
      if (complete_valid) m_busy[complete_rd] = 1'b0;
      if (acc && issue_is_long && issue_wb && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (acc && issue_is_long) m_pending = m_pending + 1;
      if (complete_valid && m_pending > 0) m_pending = m_pending - 1;
    end
  end

  task automatic idle_inputs();
    advance        = 1'b1;
    flush          = 1'b0;
    issue_valid    = 1'b0;
    issue_use_rs   = '0;
    issue_rs       = '0;
    issue_rd       = '0;
    issue_wb       = 1'b0;
    issue_is_load  = 1'b0;
    issue_is_long  = 1'b0;
    complete_valid = 1'b0;
    complete_rd    = '0;
  endtask

  task automatic set_issue(input logic [1:0] use_rs, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic wb, input logic ld, input logic lg);
    issue_valid   = 1'b1;
    issue_use_rs  = use_rs;
    issue_rs      = {rs2, rs1};
    issue_rd      = rd;
    issue_wb      = wb;
    issue_is_load = ld;
    issue_is_long = lg;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    set_issue(2'b11, 5'd5, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall got=%b want=0", stall); end
    checks++;
    if (bypass_rs !== 4'h0) begin fails++; $display("[TB] FAIL reset_bypass got=%h want=0", bypass_rs); end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (long_pending !== 3'd0) begin fails++; $display("[TB] FAIL reset_pending got=%0d want=0", long_pending); end
    next_cycle();
  endtask

  task automatic test_alu_bypass();
    logic [1:0] want [3] = '{2'd1, 2'd2, 2'd0};
    set_issue(2'b00, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin fails++; $display("[TB] FAIL alu_issue_stall got=%b want=0", stall); end
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      set_issue(2'b01, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || bypass_rs[1:0] !== want[c]) begin
        fails++;
        $display("[TB] FAIL alu_bypass_c%0d got stall=%b sel=%0d want stall=0 sel=%0d", c, stall, bypass_rs[1:0], want[c]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    set_issue(2'b00, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    next_cycle();
    set_issue(2'b10, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    advance = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin fails++; $display("[TB] FAIL load_frozen_c%0d got=%b want=1", c, stall); end
      next_cycle();
    end
    advance = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin fails++; $display("[TB] FAIL load_bubble got=%b want=1", stall); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bypass_rs[3:2] !== 2'd2) begin
      fails++;
      $display("[TB] FAIL load_release got stall=%b sel=%0d want stall=0 sel=2", stall, bypass_rs[3:2]);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_youngest();
    set_issue(2'b00, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    set_issue(2'b11, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bypass_rs !== 4'b0101) begin
      fails++;
      $display("[TB] FAIL youngest got stall=%b sel=%b want stall=0 sel=0101", stall, bypass_rs);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_long();
    set_issue(2'b00, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);
    next_cycle();
    set_issue(2'b01, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || long_pending !== 3'd1) begin
        fails++;
        $display("[TB] FAIL long_wait_c%0d got stall=%b pend=%0d want stall=1 pend=1", c, stall, long_pending);
      end
      next_cycle();
    end
    complete_valid = 1'b1;
    complete_rd    = 5'd9;
    @(negedge clk);
    checks++;
    if (stall !== !CPL_FWD || bypass_rs[1:0] !== (CPL_FWD ? 2'd3 : 2'd0)) begin
      fails++;
      $display("[TB] FAIL long_complete got stall=%b sel=%0d want stall=%b sel=%0d", stall, bypass_rs[1:0], !CPL_FWD, CPL_FWD ? 3 : 0);
    end
    next_cycle();
    complete_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bypass_rs[1:0] !== 2'd0 || long_pending !== 3'd0) begin
      fails++;
      $display("[TB] FAIL long_release got stall=%b sel=%0d pend=%0d want 0 0 0", stall, bypass_rs[1:0], long_pending);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_long_limit();
    for (int r = 10; r < 14; r++) begin
      set_issue(2'b00, 5'd0, 5'd0, 5'(r), 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin fails++; $display("[TB] FAIL long_fill_x%0d got=%b want=0", r, stall); end
      next_cycle();
    end
    set_issue(2'b00, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || long_pending !== 3'd4) begin
      fails++;
      $display("[TB] FAIL long_full got stall=%b pend=%0d want stall=1 pend=4", stall, long_pending);
    end
    next_cycle();
    idle_inputs();
    complete_valid = 1'b1;
    complete_rd    = 5'd10;
    next_cycle();
    complete_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (long_pending !== 3'd3) begin fails++; $display("[TB] FAIL long_drain got=%0d want=3", long_pending); end
    set_issue(2'b00, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1);
    complete_valid = 1'b1;
    complete_rd    = 5'd11;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (long_pending !== 3'd3) begin fails++; $display("[TB] FAIL long_inc_dec got=%0d want=3", long_pending); end
    set_issue(2'b00, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin fails++; $display("[TB] FAIL waw got=%b want=1", stall); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    set_issue(2'b00, 5'd0, 5'd0, 5'd20, 1'b1, 1'b0, 1'b0);
    next_cycle();
    set_issue(2'b11, 5'd20, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bypass_rs !== 4'h0) begin
      fails++;
      $display("[TB] FAIL mid_reset_held got stall=%b sel=%h want 0 0", stall, bypass_rs);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bypass_rs !== 4'h0 || long_pending !== 3'd0) begin
      fails++;
      $display("[TB] FAIL mid_reset_after got stall=%b sel=%h pend=%0d want 0 0 0", stall, bypass_rs, long_pending);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_x0_unused();
    set_issue(2'b00, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    next_cycle();
    advance = 1'b0;
    set_issue(2'b00, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bypass_rs !== 4'h0) begin
      fails++;
      $display("[TB] FAIL unused_src got stall=%b sel=%h want 0 0", stall, bypass_rs);
    end
    next_cycle();
    set_issue(2'b11, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bypass_rs !== 4'h0) begin
      fails++;
      $display("[TB] FAIL x0_src got stall=%b sel=%h want 0 0", stall, bypass_rs);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_flush();
    set_issue(2'b00, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    set_issue(2'b01, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || long_pending !== 3'd0) begin
      fails++;
      $display("[TB] FAIL flush_long got stall=%b pend=%0d want 0 0", stall, long_pending);
    end
    next_cycle();
    set_issue(2'b00, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    next_cycle();
    set_issue(2'b01, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin fails++; $display("[TB] FAIL flush_hazard got=%b want=1", stall); end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_random();
    logic       exp_st;
    logic [3:0] exp_byp;
    int         kind;
    for (int c = 0; c < 600; c++) begin
      rst            = ($urandom_range(0, 63) == 0);
      advance        = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 9) == 0);
      issue_valid    = ($urandom_range(0, 4) != 0);
      issue_use_rs   = 2'($urandom_range(0, 3));
      issue_rs       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      issue_rd       = 5'($urandom_range(0, 7));
      issue_wb       = ($urandom_range(0, 4) != 0);
      kind           = $urandom_range(0, 3);
      issue_is_load  = (kind == 1);
      issue_is_long  = (kind == 2);
      complete_valid = (m_pending > 0) && ($urandom_range(0, 3) == 0);
      complete_rd    = 5'($urandom_range(1, 7));
      @(negedge clk);
      model_eval(exp_st, exp_byp);
      checks++;
      if (stall !== exp_st || bypass_rs !== exp_byp || long_pending !== 3'(m_pending)) begin
        fails++;
        $display("[TB] FAIL random_c%0d got stall=%b sel=%b pend=%0d want stall=%b sel=%b pend=%0d",
                 c, stall, bypass_rs, long_pending, exp_st, exp_byp, m_pending);
      end
      next_cycle();
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_bypass();
    test_load_use();
    test_youngest();
    test_long();
    test_long_limit();
    test_reset_mid();
    test_x0_unused();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
